// File: rtl/track_collision_scanner.sv
// rtl/track_collision_scanner.sv - segment-table collision scanner for a track car
// Walks the segment table one entry per cycle through a two-stage evaluate/accumulate pipeline.

module track_collision_scanner #(
  parameter int NUM_SEG = 8,
  parameter int COOR_W  = 12,
  parameter int VEL_W   = 10,
  localparam int SEG_IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_en,
  input  logic [SEG_IDX_W-1:0]        i_wr_addr,
  input  logic [1:0]                  i_wr_type,
  input  logic signed [COOR_W-1:0]    i_wr_x_lo,
  input  logic signed [COOR_W-1:0]    i_wr_x_hi,
  input  logic signed [COOR_W-1:0]    i_wr_y_lo,
  input  logic signed [COOR_W-1:0]    i_wr_y_hi,
  input  logic signed [COOR_W-1:0]    i_wr_cx,
  input  logic signed [COOR_W-1:0]    i_wr_cy,
  input  logic signed [COOR_W-1:0]    i_wr_r_in,
  input  logic signed [COOR_W-1:0]    i_wr_r_out,
  input  logic                        i_start,
  input  logic signed [COOR_W-1:0]    i_x,
  input  logic signed [COOR_W-1:0]    i_y,
  input  logic signed [COOR_W-1:0]    i_radius,
  input  logic signed [VEL_W-1:0]     i_v_x,
  input  logic signed [VEL_W-1:0]     i_v_y,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_in_region,
  output logic                        o_off_track,
  output logic                        o_collide_x,
  output logic                        o_collide_y,
  output logic                        o_collision,
  output logic [SEG_IDX_W-1:0]        o_seg_idx
);
  localparam int D_W = COOR_W + 1;
  localparam int M_W = COOR_W + 2;
  localparam int S_W = 2 * COOR_W + 3;
  localparam int P_W = COOR_W + VEL_W + 2;
  localparam logic [SEG_IDX_W-1:0] LAST_IDX = SEG_IDX_W'(NUM_SEG - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic start_ok, wr_ok, drain_cnt;
  logic [SEG_IDX_W-1:0] scan_idx;

  logic [1:0]               t_type [NUM_SEG];
  logic signed [COOR_W-1:0] t_xlo [NUM_SEG], t_xhi [NUM_SEG], t_ylo [NUM_SEG], t_yhi [NUM_SEG];
  logic signed [COOR_W-1:0] t_cx [NUM_SEG], t_cy [NUM_SEG], t_rin [NUM_SEG], t_rout [NUM_SEG];

  logic signed [COOR_W-1:0] q_x, q_y, q_r;
  logic signed [VEL_W-1:0]  q_vx, q_vy;

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    case (state)
      IDLE:  if (i_start) begin state_nxt = SCAN; start_ok = 1'b1; end
      SCAN:  if (scan_idx == LAST_IDX) state_nxt = DRAIN;
      DRAIN: if (drain_cnt) state_nxt = DONE;
      DONE: begin
        state_nxt = i_start ? SCAN : IDLE;
        start_ok  = i_start;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state == SCAN) || (state == DRAIN);
  assign o_done = (state == DONE);
  assign wr_ok  = i_wr_en && ((state == IDLE) || (state == DONE));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      scan_idx  <= '0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      if (start_ok) scan_idx <= '0;
      else if (state == SCAN) scan_idx <= scan_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && start_ok) begin
      q_x  <= i_x;
      q_y  <= i_y;
      q_r  <= i_radius;
      q_vx <= i_v_x;
      q_vy <= i_v_y;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_SEG; i++) t_type[i] <= 2'd3;
    end else if (wr_ok) begin
      t_type[i_wr_addr] <= i_wr_type;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_ok) begin
      t_xlo[i_wr_addr]  <= i_wr_x_lo;
      t_xhi[i_wr_addr]  <= i_wr_x_hi;
      t_ylo[i_wr_addr]  <= i_wr_y_lo;
      t_yhi[i_wr_addr]  <= i_wr_y_hi;
      t_cx[i_wr_addr]   <= i_wr_cx;
      t_cy[i_wr_addr]   <= i_wr_cy;
      t_rin[i_wr_addr]  <= i_wr_r_in;
      t_rout[i_wr_addr] <= i_wr_r_out;
    end
  end

  // Stage 1: box edge distances, border margins, circle squares and the velocity dot product.
  logic signed [D_W-1:0] dx_c, dy_c, dxl, dxh, dyl, dyh;
  logic signed [M_W-1:0] mxl, mxh, myl, myh;
  logic signed [S_W-1:0] rin_sum, rout_dif, dsq, rin_sq, rout_sq;
  logic signed [P_W-1:0] dot;

  always_comb begin
    dx_c     = D_W'(q_x) - D_W'(t_cx[scan_idx]);
    dy_c     = D_W'(q_y) - D_W'(t_cy[scan_idx]);
    dxl      = D_W'(q_x) - D_W'(t_xlo[scan_idx]);
    dxh      = D_W'(t_xhi[scan_idx]) - D_W'(q_x);
    dyl      = D_W'(q_y) - D_W'(t_ylo[scan_idx]);
    dyh      = D_W'(t_yhi[scan_idx]) - D_W'(q_y);
    mxl      = M_W'(q_x) - M_W'(q_r) - M_W'(t_xlo[scan_idx]);
    mxh      = M_W'(t_xhi[scan_idx]) - M_W'(q_x) - M_W'(q_r);
    myl      = M_W'(q_y) - M_W'(q_r) - M_W'(t_ylo[scan_idx]);
    myh      = M_W'(t_yhi[scan_idx]) - M_W'(q_y) - M_W'(q_r);
    rin_sum  = S_W'(t_rin[scan_idx]) + S_W'(q_r);
    rout_dif = S_W'(t_rout[scan_idx]) - S_W'(q_r);
    dsq      = S_W'(dx_c) * S_W'(dx_c) + S_W'(dy_c) * S_W'(dy_c);
    rin_sq   = rin_sum * rin_sum;
    rout_sq  = rout_dif * rout_dif;
    dot      = P_W'(q_vx) * P_W'(dx_c) + P_W'(q_vy) * P_W'(dy_c);
  end

  logic                  s1_valid;
  logic [SEG_IDX_W-1:0]  s1_idx;
  logic [1:0]            s1_type;
  logic signed [D_W-1:0] s1_dxl, s1_dxh, s1_dyl, s1_dyh;
  logic signed [M_W-1:0] s1_mxl, s1_mxh, s1_myl, s1_myh;
  logic signed [S_W-1:0] s1_dsq, s1_rin_sq, s1_rout_sq;
  logic signed [P_W-1:0] s1_dot;

  always_ff @(posedge i_clk) begin
    if (i_rst) s1_valid <= 1'b0;
    else       s1_valid <= (state == SCAN);
  end

  always_ff @(posedge i_clk) begin
    s1_idx     <= scan_idx;
    s1_type    <= t_type[scan_idx];
    s1_dxl     <= dxl;
    s1_dxh     <= dxh;
    s1_dyl     <= dyl;
    s1_dyh     <= dyh;
    s1_mxl     <= mxl;
    s1_mxh     <= mxh;
    s1_myl     <= myl;
    s1_myh     <= myh;
    s1_dsq     <= dsq;
    s1_rin_sq  <= rin_sq;
    s1_rout_sq <= rout_sq;
    s1_dot     <= dot;
  end

  // Stage 2: sign-bit compares against zero, then OR into the accumulators.
  logic in_box, in_hit, circ_hit, hit_x, hit_y;
  logic vx_pos, vx_neg, vy_pos, vy_neg;

  always_comb begin
    vx_pos   = !q_vx[VEL_W-1] && (|q_vx);
    vx_neg   = q_vx[VEL_W-1];
    vy_pos   = !q_vy[VEL_W-1] && (|q_vy);
    vy_neg   = q_vy[VEL_W-1];
    in_box   = !s1_dxl[D_W-1] && (|s1_dxl) && !s1_dxh[D_W-1] &&
               !s1_dyl[D_W-1] && (|s1_dyl) && !s1_dyh[D_W-1];
    in_hit   = s1_valid && in_box && (s1_type != 2'd3);
    circ_hit = ((s1_dsq <= s1_rin_sq) && s1_dot[P_W-1]) ||
               ((s1_dsq >= s1_rout_sq) && !s1_dot[P_W-1] && (|s1_dot));
    hit_x    = 1'b0;
    hit_y    = 1'b0;
    if (in_hit) begin
      case (s1_type)
        2'd0: hit_y = ((s1_myh[M_W-1] || ~|s1_myh) && vy_pos) ||
                      ((s1_myl[M_W-1] || ~|s1_myl) && vy_neg);
        2'd1: hit_x = ((s1_mxl[M_W-1] || ~|s1_mxl) && vx_neg) ||
                      ((s1_mxh[M_W-1] || ~|s1_mxh) && vx_pos);
        2'd2: begin
          hit_x = circ_hit && (|q_vx);
          hit_y = circ_hit && (|q_vy);
        end
        default: ;
      endcase
    end
  end

  logic acc_in, acc_cx, acc_cy;
  logic [SEG_IDX_W-1:0] acc_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst || start_ok) begin
      acc_in  <= 1'b0;
      acc_cx  <= 1'b0;
      acc_cy  <= 1'b0;
      acc_idx <= '0;
    end else begin
      if (in_hit) acc_in <= 1'b1;
      if (hit_x || hit_y) begin
        acc_cx <= acc_cx | hit_x;
        acc_cy <= acc_cy | hit_y;
        if (!(acc_cx || acc_cy)) acc_idx <= s1_idx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_in_region <= 1'b0;
      o_off_track <= 1'b0;
      o_collide_x <= 1'b0;
      o_collide_y <= 1'b0;
      o_collision <= 1'b0;
      o_seg_idx   <= '0;
    end else if ((state == DRAIN) && drain_cnt) begin
      o_in_region <= acc_in;
      o_off_track <= !acc_in;
      o_collide_x <= acc_cx;
      o_collide_y <= acc_cy;
      o_collision <= acc_cx | acc_cy;
      o_seg_idx   <= acc_idx;
    end
  end
endmodule

// File: tb/tb_track_collision_scanner.sv
// tb/tb_track_collision_scanner.sv - randomized scoreboard bench for track_collision_scanner
// Expected query results come from a table-walking reference model and are checked on o_done.

module tb_track_collision_scanner;
  localparam int NUM_SEG = 8;
  localparam int COOR_W  = 12;
  localparam int VEL_W   = 10;
  localparam int IW      = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [1:0] wr_type = '0;
  logic signed [COOR_W-1:0] wr_x_lo = '0, wr_x_hi = '0, wr_y_lo = '0, wr_y_hi = '0;
  logic signed [COOR_W-1:0] wr_cx = '0, wr_cy = '0, wr_r_in = '0, wr_r_out = '0;
  logic start = 1'b0;
  logic signed [COOR_W-1:0] x = '0, y = '0, radius = '0;
  logic signed [VEL_W-1:0] v_x = '0, v_y = '0;
  logic busy, done, in_region, off_track, collide_x, collide_y, collision;
  logic [IW-1:0] seg_idx;

  typedef struct {
    int in_region; int off_track; int cx; int cy; int coll; int idx; int start_cyc;
  } exp_t;
  exp_t sb[$];

  int m_type [NUM_SEG], m_xlo [NUM_SEG], m_xhi [NUM_SEG], m_ylo [NUM_SEG], m_yhi [NUM_SEG];
  int m_cx [NUM_SEG], m_cy [NUM_SEG], m_rin [NUM_SEG], m_rout [NUM_SEG];
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  track_collision_scanner #(.NUM_SEG(NUM_SEG), .COOR_W(COOR_W), .VEL_W(VEL_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_type(wr_type),
    .i_wr_x_lo(wr_x_lo), .i_wr_x_hi(wr_x_hi), .i_wr_y_lo(wr_y_lo), .i_wr_y_hi(wr_y_hi),
    .i_wr_cx(wr_cx), .i_wr_cy(wr_cy), .i_wr_r_in(wr_r_in), .i_wr_r_out(wr_r_out),
    .i_start(start), .i_x(x), .i_y(y), .i_radius(radius), .i_v_x(v_x), .i_v_y(v_y),
    .o_busy(busy), .o_done(done), .o_in_region(in_region), .o_off_track(off_track),
    .o_collide_x(collide_x), .o_collide_y(collide_y), .o_collision(collision),
    .o_seg_idx(seg_idx)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  // Reference: scan every enabled segment with plain integer geometry.
  function automatic exp_t model(input int px, input int py, input int pr, input int vx, input int vy);
    exp_t e;
    bit hx, hy, c;
    longint d2, ri2, ro2, dt;
    e.in_region = 0; e.cx = 0; e.cy = 0; e.coll = 0; e.idx = 0; e.start_cyc = 0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (m_type[i] == 3) continue;
      if (!(px > m_xlo[i] && px <= m_xhi[i] && py > m_ylo[i] && py <= m_yhi[i])) continue;
      e.in_region = 1;
      hx = 0;
      hy = 0;
      if (m_type[i] == 0) begin
        hy = ((m_yhi[i] - py - pr <= 0) && vy > 0) || ((py - pr - m_ylo[i] <= 0) && vy < 0);
      end else if (m_type[i] == 1) begin
        hx = ((px - pr - m_xlo[i] <= 0) && vx < 0) || ((m_xhi[i] - px - pr <= 0) && vx > 0);
      end else begin
        d2  = longint'(px - m_cx[i]) ** 2 + longint'(py - m_cy[i]) ** 2;
        ri2 = longint'(m_rin[i] + pr) ** 2;
        ro2 = longint'(m_rout[i] - pr) ** 2;
        dt  = longint'(vx) * (px - m_cx[i]) + longint'(vy) * (py - m_cy[i]);
        c   = (d2 <= ri2 && dt < 0) || (d2 >= ro2 && dt > 0);
        hx  = c && vx != 0;
        hy  = c && vy != 0;
      end
      if (hx || hy) begin
        if (e.coll == 0) e.idx = i;
        e.coll = 1;
        if (hx) e.cx = 1;
        if (hy) e.cy = 1;
      end
    end
    e.off_track = (e.in_region == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input int t, input int xlo, input int xhi, input int ylo,
                             input int yhi, input int cx, input int cy, input int rin, input int rout);
    wr_addr = IW'(a); wr_type = 2'(t);
    wr_x_lo = COOR_W'(xlo); wr_x_hi = COOR_W'(xhi); wr_y_lo = COOR_W'(ylo); wr_y_hi = COOR_W'(yhi);
    wr_cx = COOR_W'(cx); wr_cy = COOR_W'(cy); wr_r_in = COOR_W'(rin); wr_r_out = COOR_W'(rout);
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    m_type[a] = t; m_xlo[a] = xlo; m_xhi[a] = xhi; m_ylo[a] = ylo; m_yhi[a] = yhi;
    m_cx[a] = cx; m_cy[a] = cy; m_rin[a] = rin; m_rout[a] = rout;
  endtask

  task automatic disable_all();
    for (int i = 0; i < NUM_SEG; i++) write_entry(i, 3, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    check("done_seen", int'(done), 1);
  endtask

  // Issues a query now; poke drives i_start and i_wr_en during the scan, which must be ignored.
  task automatic run_query(input int qx, input int qy, input int qr, input int qvx, input int qvy,
                           input bit poke);
    exp_t e;
    e = model(qx, qy, qr, qvx, qvy);
    e.start_cyc = cyc;
    sb.push_back(e);
    x = COOR_W'(qx); y = COOR_W'(qy); radius = COOR_W'(qr); v_x = VEL_W'(qvx); v_y = VEL_W'(qvy);
    start = 1'b1;
    step();
    start = 1'b0;
    x = COOR_W'($urandom); y = COOR_W'($urandom); radius = COOR_W'($urandom);
    v_x = VEL_W'($urandom); v_y = VEL_W'($urandom);
    if (poke) begin
      wr_addr = 3'd1; wr_type = 2'd3; wr_en = 1'b1; start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      wr_en = 1'b0; start = 1'b0;
    end
    wait_done();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("latency", cyc - e.start_cyc, NUM_SEG + 3);
        check("in_region", int'(in_region), e.in_region);
        check("off_track", int'(off_track), e.off_track);
        check("collide_x", int'(collide_x), e.cx);
        check("collide_y", int'(collide_y), e.cy);
        check("collision", int'(collision), e.coll);
        check("seg_idx", int'(seg_idx), e.idx);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones, qx, qy, qr, qvx, qvy, t, xl, yl, ri;
    for (int i = 0; i < NUM_SEG; i++) begin
      m_type[i] = 3; m_xlo[i] = 0; m_xhi[i] = 0; m_ylo[i] = 0; m_yhi[i] = 0;
      m_cx[i] = 0; m_cy[i] = 0; m_rin[i] = 0; m_rout[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_region", int'(in_region), 0);
    check("rst_off_track", int'(off_track), 0);
    check("rst_collision", int'(collision), 0);
    check("rst_seg_idx", int'(seg_idx), 0);

    step();
    write_entry(0, 0, 0, 100, 0, 40, 0, 0, 0, 0);
    run_query(50, 37, 4, 0, 3, 0);
    check("hz_collide_y", int'(collide_y), 1);
    check("hz_collide_x", int'(collide_x), 0);

    step();
    write_entry(0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    write_entry(2, 2, -60, 60, -60, 60, 0, 0, 20, 60);
    run_query(0, 57, 4, 0, 2, 0);
    check("circ_out_collide_y", int'(collide_y), 1);
    check("circ_out_seg_idx", int'(seg_idx), 2);
    step();
    run_query(0, 57, 4, 0, -2, 0);
    check("circ_in_collision", int'(collision), 0);
    check("circ_in_region", int'(in_region), 1);

    step();
    disable_all();
    run_query(rnd(-200, 200), rnd(-200, 200), rnd(0, 30), rnd(-511, 511), rnd(-511, 511), 0);
    check("disabled_off_track", int'(off_track), 1);

    step();
    write_entry(1, 1, 0, 100, 0, 100, 0, 0, 0, 0);
    write_entry(5, 1, 0, 100, 0, 100, 0, 0, 0, 0);
    run_query(95, 50, 10, 5, 0, 1);
    check("vert_seg_idx", int'(seg_idx), 1);
    check("vert_collide_x", int'(collide_x), 1);
    step();
    run_query(95, 50, 10, 5, 0, 0);
    check("table_unchanged_idx", int'(seg_idx), 1);

    step();
    disable_all();
    write_entry(3, 0, 10, 100, 0, 50, 0, 0, 0, 0);
    run_query(10, 20, 0, 0, 0, 0);
    check("edge_x_lo_region", int'(in_region), 0);
    step();
    run_query(100, 20, 0, 0, 0, 0);
    check("edge_x_hi_region", int'(in_region), 1);

    step();
    write_entry(0, 0, 0, 100, 0, 40, 0, 0, 0, 0);
    x = 12'sd50; y = 12'sd37; radius = 12'sd4; v_x = '0; v_y = 10'sd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("abort_busy_before", int'(busy), 1);
    rst = 1'b1; start = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_type = 2'd0;
    step();
    rst = 1'b0; start = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < NUM_SEG; i++) m_type[i] = 3;
    check("abort_busy_after", int'(busy), 0);
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    step();
    run_query(50, 37, 4, 0, 3, 0);
    check("abort_table_off_track", int'(off_track), 1);

    for (int it = 0; it < 25; it++) begin
      step();
      for (int i = 0; i < NUM_SEG; i++) begin
        t = rnd(0, 3); xl = rnd(-200, 100); yl = rnd(-200, 100); ri = rnd(0, 120);
        write_entry(i, t, xl, xl + rnd(0, 250), yl, yl + rnd(0, 250),
                    rnd(-100, 100), rnd(-100, 100), ri, ri + rnd(0, 150));
      end
      for (int q = 0; q < 3; q++) begin
        if (q != 2) step();
        qx = (rnd(0, 3) == 0) ? m_xhi[rnd(0, NUM_SEG - 1)] : rnd(-200, 200);
        qy = (rnd(0, 3) == 0) ? m_ylo[rnd(0, NUM_SEG - 1)] : rnd(-200, 200);
        qr = rnd(0, 30);
        qvx = (rnd(0, 3) == 0) ? 0 : rnd(-511, 511);
        qvy = (rnd(0, 3) == 0) ? 0 : rnd(-511, 511);
        run_query(qx, qy, qr, qvx, qvy, 0);
      end
    end

    step();
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
